pixel_dispatcher: RTL and testbench

//  Initiator side of the depth-calculator handshake. Walks an H_RES x V_RES raster, maps each pixel to a

---
 rtl/mandelbrot_pkg.sv | 19 +
 rtl/pixel_dispatcher_coord_stepper.sv | 62 ++++++
 rtl/pixel_dispatcher.sv | 176 +++++++++++++++++
 tb/tb_pixel_dispatcher.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared widths, raster defaults and the dispatcher state encoding for the
// Mandelbrot render path.
package mandelbrot_pkg;

   localparam int DEFAULT_H_RES = 640;
   localparam int DEFAULT_V_RES = 480;
   localparam int COORD_W       = 32;
   localparam int DEPTH_W       = 8;
   localparam int X_W           = 10;
   localparam int Y_W           = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      EMIT  = 2'd3
   } dispatch_state_t;

endpackage

// File: rtl/pixel_dispatcher_coord_stepper.sv
// Raster walker: tracks pixel x/y and the complex coordinate of the current
// pixel with adders only (re steps along a line, im steps down per line).
module coord_stepper
   import mandelbrot_pkg::*;
#(
   parameter int H_RES = DEFAULT_H_RES,
   parameter int V_RES = DEFAULT_V_RES
) (
   input  logic               sysclk,
   input  logic               reset_n,
   input  logic               load,
   input  logic               advance,
   input  logic [COORD_W-1:0] re_origin,
   input  logic [COORD_W-1:0] im_origin,
   input  logic [COORD_W-1:0] step,
   output logic [X_W-1:0]     x,
   output logic [Y_W-1:0]     y,
   output logic [COORD_W-1:0] re_acc,
   output logic [COORD_W-1:0] im_acc,
   output logic               last_pixel,
   output logic               eol
);

   localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

   logic [COORD_W-1:0] re_base;
   logic [COORD_W-1:0] step_q;

   assign eol        = (x == X_LAST);
   assign last_pixel = eol && (y == Y_LAST);

   // The final pixel is held rather than advanced so the idle outputs stay in range.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         x       <= '0;
         y       <= '0;
         re_acc  <= '0;
         im_acc  <= '0;
         re_base <= '0;
         step_q  <= '0;
      end else if (load) begin
         x       <= '0;
         y       <= '0;
         re_acc  <= re_origin;
         im_acc  <= im_origin;
         re_base <= re_origin;
         step_q  <= step;
      end else if (advance && !last_pixel) begin
         if (eol) begin
            x      <= '0;
            re_acc <= re_base;
            y      <= y + 1'b1;
            im_acc <= im_acc - step_q;
         end else begin
            x      <= x + 1'b1;
            re_acc <= re_acc + step_q;
         end
      end
   end

endmodule

// File: rtl/pixel_dispatcher.sv
// Issues one depth calculation per raster pixel and streams each result out as
// a valid/ready beat. Optional WAIT watchdog: define DISPATCH_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | no frame in flight, waiting for frame_start
//  ISSUE | one-cycle calc_start for the current pixel
//  WAIT  | waiting for a calc_done rising edge (or watchdog expiry)
//  EMIT  | result beat offered downstream until accepted
module pixel_dispatcher
   import mandelbrot_pkg::*;
#(
   parameter int H_RES   = DEFAULT_H_RES,
   parameter int V_RES   = DEFAULT_V_RES,
   parameter int FRAC    = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic               sysclk,
   input  logic               reset_n,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] re_origin,
   input  logic [COORD_W-1:0] im_origin,
   input  logic [COORD_W-1:0] step,
   output logic               frame_busy,
   output logic               frame_done,
   output logic               calc_start,
   output logic [X_W-1:0]     calc_x,
   output logic [Y_W-1:0]     calc_y,
   output logic [COORD_W-1:0] calc_re_c,
   output logic [COORD_W-1:0] calc_im_c,
   input  logic [DEPTH_W-1:0] calc_depth,
   input  logic               calc_done,
`ifdef DISPATCH_TIMEOUT_EN
   output logic               calc_timeout,
`endif
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [X_W-1:0]     pix_x,
   output logic [Y_W-1:0]     pix_y,
   output logic [DEPTH_W-1:0] pix_depth,
   output logic               pix_sof,
   output logic               pix_eol
);

   if (FRAC >= COORD_W || FRAC < 0 || TIMEOUT < 1) begin : g_param_check
      $error("pixel_dispatcher: FRAC must fit the coordinate word and TIMEOUT must be >= 1");
   end

   dispatch_state_t    state, state_nxt;
   logic               done_q;
   logic               capture;
   logic               tmo_tc;
   logic               load;
   logic               advance;
   logic               last_pixel;
   logic               eol;
   logic               frame_done_q;
   logic [DEPTH_W-1:0] depth_q;
   logic [X_W-1:0]     x;
   logic [Y_W-1:0]     y;
   logic [COORD_W-1:0] re_acc;
   logic [COORD_W-1:0] im_acc;

   assign load    = (state == IDLE) && frame_start;
   assign advance = (state == EMIT) && pix_ready;
   // calc_done is a level; only its 0->1 edge inside WAIT is a fresh result.
   assign capture = (state == WAIT) && calc_done && !done_q;

   coord_stepper #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_stepper (
      .sysclk     (sysclk),
      .reset_n    (reset_n),
      .load       (load),
      .advance    (advance),
      .re_origin  (re_origin),
      .im_origin  (im_origin),
      .step       (step),
      .x          (x),
      .y          (y),
      .re_acc     (re_acc),
      .im_acc     (im_acc),
      .last_pixel (last_pixel),
      .eol        (eol)
   );

`ifdef DISPATCH_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_cnt;

   // Loaded in ISSUE so WAIT lasts exactly TIMEOUT cycles before expiry.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt <= '0;
      end else if (state == ISSUE) begin
         tmo_cnt <= TMO_W'(TIMEOUT - 1);
      end else if ((state == WAIT) && (tmo_cnt != '0)) begin
         tmo_cnt <= tmo_cnt - 1'b1;
      end
   end

   assign tmo_tc = (state == WAIT) && !capture && (tmo_cnt == '0);

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         calc_timeout <= 1'b0;
      end else if (load) begin
         calc_timeout <= 1'b0;
      end else if (tmo_tc) begin
         calc_timeout <= 1'b1;
      end
   end
`else
   assign tmo_tc = 1'b0;
`endif

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_start) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (capture || tmo_tc) state_nxt = EMIT;
         EMIT:    if (pix_ready) state_nxt = last_pixel ? IDLE : ISSUE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      frame_busy = 1'b1;
      calc_start = 1'b0;
      pix_valid  = 1'b0;
      case (state)
         IDLE:    frame_busy = 1'b0;
         ISSUE:   calc_start = 1'b1;
         EMIT:    pix_valid  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         done_q       <= 1'b0;
         depth_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         done_q       <= calc_done;
         frame_done_q <= advance && last_pixel;
         if (capture) begin
            depth_q <= calc_depth;
         end else if (tmo_tc) begin
            depth_q <= '1;
         end
      end
   end

   assign frame_done = frame_done_q;
   assign calc_x     = x;
   assign calc_y     = y;
   assign calc_re_c  = re_acc;
   assign calc_im_c  = im_acc;
   assign pix_x      = x;
   assign pix_y      = y;
   assign pix_depth  = depth_q;
   assign pix_sof    = pix_valid && (x == '0) && (y == '0);
   assign pix_eol    = pix_valid && eol;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher on a 4x2 raster with a 3-cycle behavioural
// depth calculator; the watchdog frame runs only when DISPATCH_TIMEOUT_EN is defined.
module tb_pixel_dispatcher;
   import mandelbrot_pkg::*;

   localparam int H   = 4;
   localparam int V   = 2;
   localparam int TMO = 16;

   logic        sysclk      = 1'b0;
   logic        reset_n     = 1'b0;
   logic        frame_start = 1'b0;
   logic [31:0] re_origin   = '0;
   logic [31:0] im_origin   = '0;
   logic [31:0] step        = '0;
   logic        frame_busy, frame_done, calc_start;
   logic [9:0]  calc_x;
   logic [8:0]  calc_y;
   logic [31:0] calc_re_c, calc_im_c;
   logic [7:0]  calc_depth  = '0;
   logic        calc_done   = 1'b0;
   logic        pix_valid;
   logic        pix_ready   = 1'b1;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic [7:0]  pix_depth;
   logic        pix_sof, pix_eol;
`ifdef DISPATCH_TIMEOUT_EN
   logic        calc_timeout;
`endif

   int          n_chk = 0;
   int          n_pass = 0;

   // calculator model controls
   int          calc_cnt  = 0;
   logic        calc_mute = 1'b0;
   logic        calc_lazy = 1'b0;
   logic [7:0]  res_ctr   = '0;

   always #5 sysclk = ~sysclk;

   pixel_dispatcher #(
      .H_RES   (H),
      .V_RES   (V),
      .FRAC    (16),
      .TIMEOUT (TMO)
   ) dut (
      .sysclk       (sysclk),
      .reset_n      (reset_n),
      .frame_start  (frame_start),
      .re_origin    (re_origin),
      .im_origin    (im_origin),
      .step         (step),
      .frame_busy   (frame_busy),
      .frame_done   (frame_done),
      .calc_start   (calc_start),
      .calc_x       (calc_x),
      .calc_y       (calc_y),
      .calc_re_c    (calc_re_c),
      .calc_im_c    (calc_im_c),
      .calc_depth   (calc_depth),
      .calc_done    (calc_done),
`ifdef DISPATCH_TIMEOUT_EN
      .calc_timeout (calc_timeout),
`endif
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .pix_depth    (pix_depth),
      .pix_sof      (pix_sof),
      .pix_eol      (pix_eol)
   );

   // Done rises 3 cycles after start and stays high until the next start.
   // A lazy calculator keeps the stale done high for one cycle after start.
   always @(posedge sysclk) begin
      if (calc_start) begin
         calc_cnt <= 2;
         if (!calc_lazy) calc_done <= 1'b0;
      end else if (calc_cnt != 0) begin
         calc_cnt <= calc_cnt - 1;
         if (calc_cnt == 2) calc_done <= 1'b0;
         if (calc_cnt == 1 && !calc_mute) begin
            calc_done  <= 1'b1;
            calc_depth <= res_ctr;
            res_ctr    <= res_ctr + 8'd1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic run_frame(input logic [31:0] ro, input logic [31:0] io, input logic [31:0] st,
                            input int stall_beat, input int mid_beat, input int abort_beat,
                            input int tmo_beat);
      logic [7:0]  exp_d;
      logic [31:0] exp_re, exp_im;
      logic [59:0] snap;
      logic        stable;
      int          lat, xx, yy;
      exp_d = res_ctr;
      @(negedge sysclk);
      re_origin   = ro;
      im_origin   = io;
      step        = st;
      frame_start = 1'b1;
      @(negedge sysclk);
      frame_start = 1'b0;
      re_origin   = 32'hDEAD_BEEF;
      im_origin   = 32'h0BAD_F00D;
      step        = 32'h1357_9BDF;
      chk("busy_on_start", frame_busy, 1);
`ifdef DISPATCH_TIMEOUT_EN
      chk("timeout_cleared", calc_timeout, 0);
`endif
      for (int k = 0; k < H * V; k++) begin
         xx = k % H;
         yy = k / H;
         chk("start_after_accept", calc_start, 1);
         if (k == abort_beat) begin
            repeat (2) @(negedge sysclk);
            reset_n = 1'b0;
            #1;
            chk("rst_busy", frame_busy, 0);
            chk("rst_start", calc_start, 0);
            chk("rst_calc_x", calc_x, 0);
            chk("rst_re_c", calc_re_c, 0);
            chk("rst_im_c", calc_im_c, 0);
            chk("rst_valid", pix_valid, 0);
            chk("rst_depth", pix_depth, 0);
            @(negedge sysclk);
            reset_n = 1'b1;
            repeat (8) @(negedge sysclk);
            return;
         end
         if (k == stall_beat) pix_ready = 1'b0;
         if (k == tmo_beat) calc_mute = 1'b1;
         lat = 0;
         while (!pix_valid && lat < 200) begin
            @(negedge sysclk);
            lat++;
         end
         chk("beat_arrives", pix_valid, 1);
         if (!pix_valid) return;
         if (k == tmo_beat) chk("timeout_latency", lat, TMO + 1);
         else chk("beat_latency", lat, 4);
         exp_re = ro + 32'(xx) * st;
         exp_im = io - 32'(yy) * st;
         chk("pix_x", pix_x, xx);
         chk("pix_y", pix_y, yy);
         chk("pix_sof", pix_sof, (k == 0));
         chk("pix_eol", pix_eol, (xx == H - 1));
         chk("pix_depth", pix_depth, (k == tmo_beat) ? 8'hFF : exp_d);
         chk("calc_re_c", calc_re_c, exp_re);
         chk("calc_im_c", calc_im_c, exp_im);
         if (k == tmo_beat) calc_mute = 1'b0;
         else exp_d = exp_d + 8'd1;
         if (k == stall_beat) begin
            snap   = {pix_x, pix_y, pix_depth, pix_sof, pix_eol, calc_re_c};
            stable = 1'b1;
            repeat (10) begin
               @(negedge sysclk);
               if ({pix_x, pix_y, pix_depth, pix_sof, pix_eol, calc_re_c} !== snap) stable = 1'b0;
               if (!pix_valid || calc_start) stable = 1'b0;
            end
            chk("stall_hold", stable, 1);
            pix_ready = 1'b1;
         end
         if (k == mid_beat) begin
            frame_start = 1'b1;
            re_origin   = 32'h1234_5678;
            im_origin   = 32'h8765_4321;
            step        = 32'h0001_0000;
         end
         @(negedge sysclk);
         frame_start = 1'b0;
      end
      chk("frame_done_pulse", frame_done, 1);
      chk("busy_cleared", frame_busy, 0);
      @(negedge sysclk);
      chk("frame_done_once", frame_done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      repeat (3) @(negedge sysclk);
      chk("reset_busy", frame_busy, 0);
      chk("reset_start", calc_start, 0);
      chk("reset_valid", pix_valid, 0);
      chk("reset_done", frame_done, 0);
      chk("reset_sof", pix_sof, 0);
      reset_n = 1'b1;
      @(negedge sysclk);

      // -2.0 + 1.0i, step 0.5
      run_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000, -1, -1, -1, -1);
      // stall beat 2 with a calculator that leaves done high into WAIT
      calc_lazy = 1'b1;
      run_frame(32'h0001_0000, 32'hFFFF_0000, 32'h0000_4000, 2, -1, -1, -1);
      calc_lazy = 1'b0;
      // re wraps past 0x7FFFFFFF; mid-frame frame_start must be ignored
      run_frame(32'h7FFF_C000, 32'h8000_2000, 32'h0000_8000, -1, 3, -1, -1);
      // reset while waiting on pixel 5, then a clean restart
      run_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000, -1, -1, 5, -1);
      run_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000, -1, -1, -1, -1);
`ifdef DISPATCH_TIMEOUT_EN
      run_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000, -1, -1, -1, 2);
      chk("timeout_sticky", calc_timeout, 1);
      run_frame(32'h0000_0000, 32'h0000_0000, 32'h0000_1000, -1, -1, -1, -1);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
